// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BTB plus 2-bit PHT fetch predictor; optional gshare indexing under BP_GSHARE_EN
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 10,
  parameter int GHR_W   = 6,
  parameter int STAT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [XLEN-1:0]   pc_f_i,
  output logic              pred_taken_o,
  output logic [XLEN-1:0]   pred_pc_o,
  output logic [GHR_W-1:0]  pred_ghr_o,
  input  logic              upd_valid_i,
  input  logic [XLEN-1:0]   upd_pc_i,
  input  logic              upd_is_branch_i,
  input  logic              upd_is_jump_i,
  input  logic              upd_taken_i,
  input  logic [XLEN-1:0]   upd_target_i,
  input  logic              upd_pred_taken_i,
  input  logic [XLEN-1:0]   upd_pred_pc_i,
  input  logic [GHR_W-1:0]  upd_ghr_i,
  output logic              mispredict_o,
  output logic [XLEN-1:0]   correct_pc_o,
  output logic [STAT_W-1:0] stat_lookups_o,
  output logic [STAT_W-1:0] stat_mispred_o
);
  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic               jump_q   [ENTRIES];
  logic [1:0]         pht_q    [ENTRIES];
  logic [STAT_W-1:0]  lookups_q;
  logic [STAT_W-1:0]  mispred_q;

  logic [IDX_W-1:0] f_idx, f_pidx, u_idx, u_pidx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             f_hit, u_hit, u_ctrl, u_cnt;

  assign f_idx  = pc_f_i[IDX_W+1:2];
  assign f_tag  = pc_f_i[IDX_W+TAG_W+1:IDX_W+2];
  assign u_idx  = upd_pc_i[IDX_W+1:2];
  assign u_tag  = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign u_ctrl = upd_is_branch_i | upd_is_jump_i;
  // Jumps are always taken, so their counter is never trained.
  assign u_cnt  = upd_is_branch_i & ~upd_is_jump_i;

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr_q;
  logic [GHR_W:0]   ghr_shift;
  logic             unused_ok;

  assign ghr_shift  = {ghr_q, upd_taken_i};
  assign f_pidx     = f_idx ^ IDX_W'(ghr_q);
  assign u_pidx     = u_idx ^ IDX_W'(upd_ghr_i);
  assign pred_ghr_o = ghr_q;
  assign unused_ok  = ^{pc_f_i, upd_pc_i, ghr_shift[GHR_W]};

  // History follows resolved outcomes only, so it needs no repair on mispredict.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ghr_q <= '0;
    end else if (upd_valid_i && upd_is_branch_i) begin
      ghr_q <= ghr_shift[GHR_W-1:0];
    end
  end
`else
  logic unused_ok;

  assign f_pidx     = f_idx;
  assign u_pidx     = u_idx;
  assign pred_ghr_o = '0;
  assign unused_ok  = ^{pc_f_i, upd_pc_i, upd_ghr_i};
`endif

  assign f_hit        = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign u_hit        = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign pred_taken_o = f_hit && (jump_q[f_idx] || pht_q[f_pidx][1]);
  assign pred_pc_o    = pred_taken_o ? target_q[f_idx] : pc_f_i + XLEN'(4);

  assign mispredict_o = upd_valid_i &&
                        ((upd_taken_i != upd_pred_taken_i) ||
                         (upd_taken_i && (upd_target_i != upd_pred_pc_i)));
  assign correct_pc_o = !upd_valid_i ? '0 :
                        (upd_taken_i ? upd_target_i : upd_pc_i + XLEN'(4));

  function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
    if (up) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    else    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) pht_q[i] <= 2'b01;
    end else if (upd_valid_i && u_ctrl) begin
      if (u_hit) begin
        if (u_cnt) pht_q[u_pidx] <= sat2(pht_q[u_pidx], upd_taken_i);
      end else if (upd_taken_i) begin
        valid_q[u_idx] <= 1'b1;
        if (u_cnt) pht_q[u_pidx] <= 2'b10;
      end
    end
  end

  // Payload needs no reset: it is only read behind a set valid bit.
  always_ff @(posedge clk_i) begin
    if (!rst_i && upd_valid_i && u_ctrl && upd_taken_i) begin
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= upd_target_i;
      jump_q[u_idx]   <= upd_is_jump_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lookups_q <= '0;
      mispred_q <= '0;
    end else begin
      if (upd_valid_i && (lookups_q != '1))  lookups_q <= lookups_q + STAT_W'(1);
      if (mispredict_o && (mispred_q != '1)) mispred_q <= mispred_q + STAT_W'(1);
    end
  end

  assign stat_lookups_o = lookups_q;
  assign stat_mispred_o = mispred_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;
  localparam int XLEN = 32, ENTRIES = 64, TAG_W = 10, GHR_W = 6, STAT_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [XLEN-1:0]   pc_f = 32'h100;
  logic              pred_taken;
  logic [XLEN-1:0]   pred_pc;
  logic [GHR_W-1:0]  pred_ghr;
  logic              upd_valid = 1'b0;
  logic [XLEN-1:0]   upd_pc = '0;
  logic              upd_is_branch = 1'b0;
  logic              upd_is_jump = 1'b0;
  logic              upd_taken = 1'b0;
  logic [XLEN-1:0]   upd_target = '0;
  logic              upd_pred_taken = 1'b0;
  logic [XLEN-1:0]   upd_pred_pc = '0;
  logic [GHR_W-1:0]  upd_ghr = '0;
  logic              mispredict;
  logic [XLEN-1:0]   correct_pc;
  logic [STAT_W-1:0] stat_lookups;
  logic [STAT_W-1:0] stat_mispred;

  int errors = 0;
  int checks = 0;

  branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .GHR_W(GHR_W), .STAT_W(STAT_W)) dut (
    .clk_i(clk), .rst_i(rst), .pc_f_i(pc_f),
    .pred_taken_o(pred_taken), .pred_pc_o(pred_pc), .pred_ghr_o(pred_ghr),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_is_branch_i(upd_is_branch),
    .upd_is_jump_i(upd_is_jump), .upd_taken_i(upd_taken), .upd_target_i(upd_target),
    .upd_pred_taken_i(upd_pred_taken), .upd_pred_pc_i(upd_pred_pc), .upd_ghr_i(upd_ghr),
    .mispredict_o(mispredict), .correct_pc_o(correct_pc),
    .stat_lookups_o(stat_lookups), .stat_mispred_o(stat_mispred)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic br, input logic jmp, input logic tk,
                           input logic [31:0] tgt, input logic ptk, input logic [31:0] ppc);
    upd_valid = 1'b1; upd_pc = pc; upd_is_branch = br; upd_is_jump = jmp;
    upd_taken = tk; upd_target = tgt; upd_pred_taken = ptk; upd_pred_pc = ppc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    upd_valid = 1'b0;
    #1;
  endtask

  task automatic resolve(input string tag, input logic [31:0] pc, input logic br, input logic jmp,
                         input logic tk, input logic [31:0] tgt, input logic ptk, input logic [31:0] ppc,
                         input logic exp_mp, input logic [31:0] exp_cpc);
    drive_upd(pc, br, jmp, tk, tgt, ptk, ppc);
    check({tag, "_mp"}, 64'(mispredict), 64'(exp_mp));
    check({tag, "_cpc"}, 64'(correct_pc), 64'(exp_cpc));
    tick();
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp_tk, input logic [31:0] exp_pc);
    pc_f = pc; #1;
    check({tag, "_tk"}, 64'(pred_taken), 64'(exp_tk));
    check({tag, "_pc"}, 64'(pred_pc), 64'(exp_pc));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    look("rst_look", 32'h100, 1'b0, 32'h104);
    check("rst_ghr", 64'(pred_ghr), 64'd0);
    check("rst_mp", 64'(mispredict), 64'd0);
    check("rst_stl", 64'(stat_lookups), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    look("cold", 32'h100, 1'b0, 32'h104);

`ifndef BP_GSHARE_EN
    // learn, with same-cycle lookup showing pre-update contents
    pc_f = 32'h100;
    drive_upd(32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
    check("learn_mp", 64'(mispredict), 64'd1);
    check("learn_cpc", 64'(correct_pc), 64'h80);
    check("learn_same_cycle", 64'(pred_taken), 64'd0);
    tick();
    look("learn_next", 32'h100, 1'b1, 32'h80);

    drive_upd(32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
    check("nt1_mp", 64'(mispredict), 64'd1);
    check("nt1_cpc", 64'(correct_pc), 64'h104);
    check("nt1_same_cycle", 64'(pred_taken), 64'd1);
    tick();
    look("ctr1", 32'h100, 1'b0, 32'h104);
    resolve("nt2", 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0, 32'h104);
    look("ctr0", 32'h100, 1'b0, 32'h104);
    resolve("t1", 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80);
    look("ctr1b", 32'h100, 1'b0, 32'h104);
    resolve("t2", 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80);
    look("ctr2", 32'h100, 1'b1, 32'h80);
    check("stl5", 64'(stat_lookups), 64'd5);
    check("stm4", 64'(stat_mispred), 64'd4);
    check("ghr_off", 64'(pred_ghr), 64'd0);

    resolve("jal", 32'h200, 1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 32'h204, 1'b1, 32'h300);
    look("alias_old", 32'h100, 1'b0, 32'h104);
    look("alias_new", 32'h200, 1'b1, 32'h300);
    resolve("tgt", 32'h200, 1'b0, 1'b1, 1'b1, 32'h400, 1'b1, 32'h300, 1'b1, 32'h400);
    look("tgt_new", 32'h200, 1'b1, 32'h400);
    resolve("nonctl", 32'h500, 1'b0, 1'b0, 1'b1, 32'h900, 1'b0, 32'h504, 1'b1, 32'h900);
    look("nonctl_look", 32'h500, 1'b0, 32'h504);
    resolve("missnt", 32'h600, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h604, 1'b0, 32'h604);
    look("missnt_look", 32'h600, 1'b0, 32'h604);
    check("stl9", 64'(stat_lookups), 64'd9);
    check("stm7", 64'(stat_mispred), 64'd7);

    // wrap of both +4 paths, probed without a clock edge
    look("wrap_look", 32'hFFFF_FFFC, 1'b0, 32'h0);
    drive_upd(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10);
    check("wrap_cpc", 64'(correct_pc), 64'h0);
    upd_valid = 1'b0; #1;
    check("idle_mp", 64'(mispredict), 64'd0);
    check("idle_cpc", 64'(correct_pc), 64'd0);

    for (int i = 0; i < 8; i++)
      resolve("sat", 32'h700, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h704, 1'b1, 32'h40);
    check("sat_stl", 64'(stat_lookups), 64'd15);
    check("sat_stm", 64'(stat_mispred), 64'd15);

    // async reset in the middle of a cycle with an update pending
    look("pre_rst", 32'h200, 1'b1, 32'h400);
    drive_upd(32'h300, 1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h304);
    #1; rst = 1'b1; #1;
    check("arst_tk", 64'(pred_taken), 64'd0);
    check("arst_pc", 64'(pred_pc), 64'h204);
    check("arst_stl", 64'(stat_lookups), 64'd0);
    check("arst_mp", 64'(mispredict), 64'd1);
    @(posedge clk); #1;
    upd_valid = 1'b0;
    rst = 1'b0; #1;
    look("arst_noalloc", 32'h300, 1'b0, 32'h304);

    resolve("s1", 32'h800, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h804, 1'b1, 32'h10);
    resolve("s2", 32'h800, 1'b0, 1'b0, 1'b0, 32'h10, 1'b0, 32'h804, 1'b0, 32'h804);
    resolve("s3", 32'h800, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h804, 1'b1, 32'h10);
    resolve("s4", 32'h800, 1'b0, 1'b0, 1'b0, 32'h10, 1'b0, 32'h804, 1'b0, 32'h804);
    resolve("s5", 32'h800, 1'b0, 1'b0, 1'b0, 32'h10, 1'b0, 32'h804, 1'b0, 32'h804);
    check("st_5", 64'(stat_lookups), 64'd5);
    check("st_2", 64'(stat_mispred), 64'd2);
`else
    resolve("g_t1", 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80);
    resolve("g_t2", 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80);
    resolve("g_n", 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 32'h104);
    check("g_ghr", 64'(pred_ghr), 64'h06);
    look("g_idx_other", 32'h100, 1'b0, 32'h104);
    resolve("g_nonbr", 32'h200, 1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 32'h204, 1'b1, 32'h300);
    check("g_ghr_jmp", 64'(pred_ghr), 64'h06);
    check("g_stl", 64'(stat_lookups), 64'd4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
